// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared direction/mode constants and parameter check for up/down counters
`ifndef UPDOWN_PKG_SV
`define UPDOWN_PKG_SV

// True when WIDTH is 1..32 and MODULUS is 2..2^WIDTH.
`define UPDOWN_PARAMS_LEGAL(w, m) (((w) >= 1) && ((w) <= 32) && ((m) >= 2) && ((m) <= (64'd1 << (w))))

package updown_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

`endif

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised modulo up/down counter with load, wrap/saturate and event pulse
module updown_mod_counter
  import updown_pkg::*;
#(
  parameter int     WIDTH   = 3,
  parameter longint MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             event_pulse
);

  if (!(`UPDOWN_PARAMS_LEGAL(WIDTH, MODULUS))) begin : g_param_check
    $error("updown_mod_counter: illegal WIDTH/MODULUS combination");
  end

  // Limits are held one bit wider so MODULUS = 2^WIDTH compares correctly.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH:0]   count_ext;
  logic [WIDTH-1:0] count_nxt;
  logic             event_nxt;

  assign count_ext = {1'b0, count};

  always_comb begin
    count_nxt = count;
    event_nxt = 1'b0;
    if (load) begin
      count_nxt = ({1'b0, load_val} > MAX_EXT) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_down == DIR_UP) begin
        if (count_ext < MAX_EXT) begin
          count_nxt = WIDTH'(count_ext + 1'b1);
        end else begin
          event_nxt = 1'b1;
          if (sat_mode != MODE_SAT) count_nxt = '0;
        end
      end else begin
        if (count_ext != '0) begin
          count_nxt = WIDTH'(count_ext - 1'b1);
        end else begin
          event_nxt = 1'b1;
          if (sat_mode != MODE_SAT) count_nxt = MAX_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      event_pulse <= 1'b0;
    end else begin
      count       <= count_nxt;
      event_pulse <= event_nxt;
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed and soak checks for updown_mod_counter (MODULUS 8 and 6)
module tb_updown_mod_counter;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic       up_down  = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load     = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] count8, count6;
  logic       at_max8, at_min8, ev8;
  logic       at_max6, at_min6, ev6;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count8), .at_max(at_max8),
    .at_min(at_min8), .event_pulse(ev8)
  );

  updown_mod_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count6), .at_max(at_max6),
    .at_min(at_min6), .event_pulse(ev6)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    en = 1'b0; load = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Independent reference: returns {event, next_count} for modulus m.
  function automatic logic [3:0] ref_next(input int m, input logic [2:0] c, input logic e,
                                          input logic ud, input logic sm, input logic ld,
                                          input logic [2:0] lv);
    int top = m - 1;
    int ci  = int'(c);
    if (ld) return {1'b0, (int'(lv) > top) ? 3'(top) : lv};
    if (!e) return {1'b0, c};
    if (ud) begin
      if (ci < top) return {1'b0, 3'(ci + 1)};
      return {1'b1, sm ? c : 3'd0};
    end
    if (ci > 0) return {1'b0, 3'(ci - 1)};
    return {1'b1, sm ? c : 3'(top)};
  endfunction

  task automatic test_reset;
    #1 rst = 1'b0;
    en = 1'b1; up_down = 1'b1;
    #2;
    tests++; if (count8 !== 3'd0) begin errors++; $display("FAIL reset_count8: got %0d want 0", count8); end
    tests++; if (ev8 !== 1'b0) begin errors++; $display("FAIL reset_event8: got %b want 0", ev8); end
    tests++; if (at_min8 !== 1'b1 || at_max8 !== 1'b0) begin errors++; $display("FAIL reset_flags8: got min=%b max=%b want min=1 max=0", at_min8, at_max8); end
    tests++; if (count6 !== 3'd0) begin errors++; $display("FAIL reset_count6: got %0d want 0", count6); end
    step();
    tests++; if (count8 !== 3'd0) begin errors++; $display("FAIL reset_hold_edge: got %0d want 0", count8); end
    en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_count;
    apply_reset();
    load = 1'b1; load_val = 3'd5;
    step();
    load = 1'b0;
    tests++; if (count8 !== 3'd5) begin errors++; $display("FAIL midrst_preload: got %0d want 5", count8); end
    #3 rst = 1'b0;
    #1;
    tests++; if (count8 !== 3'd0 || ev8 !== 1'b0 || at_min8 !== 1'b1) begin errors++; $display("FAIL midrst_async: got count=%0d ev=%b min=%b want 0/0/1", count8, ev8, at_min8); end
    #1 rst = 1'b1;
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
    step();
    en = 1'b0;
    tests++; if (count8 !== 3'd0 || ev8 !== 1'b1) begin errors++; $display("FAIL midrst_wrap_setup: got count=%0d ev=%b want 0/1", count8, ev8); end
    #3 rst = 1'b0;
    #1;
    tests++; if (ev8 !== 1'b0) begin errors++; $display("FAIL midrst_event_clear: got %b want 0", ev8); end
    #1 rst = 1'b1;
  endtask

  task automatic test_up_wrap;
    logic [2:0] exp;
    apply_reset();
    en = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      exp = 3'((i + 1) % 8);
      tests++; if (count8 !== exp) begin errors++; $display("FAIL up_wrap_count[%0d]: got %0d want %0d", i, count8, exp); end
      tests++; if (ev8 !== (exp == 3'd0)) begin errors++; $display("FAIL up_wrap_event[%0d]: got %b want %b", i, ev8, (exp == 3'd0)); end
      tests++; if (at_max8 !== (exp == 3'd7)) begin errors++; $display("FAIL up_wrap_at_max[%0d]: got %b want %b", i, at_max8, (exp == 3'd7)); end
    end
    en = 1'b0;
  endtask

  task automatic test_down_sat;
    logic [2:0] exp_c [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
    logic       exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 3'd2;
    step();
    tests++; if (count6 !== 3'd2) begin errors++; $display("FAIL down_sat_load: got %0d want 2", count6); end
    load = 1'b0; en = 1'b1; up_down = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (count6 !== exp_c[i]) begin errors++; $display("FAIL down_sat_count[%0d]: got %0d want %0d", i, count6, exp_c[i]); end
      tests++; if (ev6 !== exp_e[i]) begin errors++; $display("FAIL down_sat_event[%0d]: got %b want %b", i, ev6, exp_e[i]); end
      tests++; if (count6 > 3'd5) begin errors++; $display("FAIL down_sat_range[%0d]: got %0d want <=5", i, count6); end
    end
  endtask

  task automatic test_load_priority;
    load = 1'b1; en = 1'b1; up_down = 1'b0; load_val = 3'd7;
    step();
    tests++; if (count6 !== 3'd5 || at_max6 !== 1'b1) begin errors++; $display("FAIL load_clamp6: got count=%0d max=%b want 5/1", count6, at_max6); end
    tests++; if (ev6 !== 1'b0) begin errors++; $display("FAIL load_no_event: got %b want 0", ev6); end
    tests++; if (count8 !== 3'd7) begin errors++; $display("FAIL load_full8: got %0d want 7", count8); end
    load_val = 3'd3;
    step();
    tests++; if (count6 !== 3'd3) begin errors++; $display("FAIL load_three: got %0d want 3", count6); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_down_wrap;
    load = 1'b1; load_val = 3'd0;
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b0; sat_mode = 1'b0;
    step();
    tests++; if (count6 !== 3'd5 || ev6 !== 1'b1) begin errors++; $display("FAIL down_wrap6: got count=%0d ev=%b want 5/1", count6, ev6); end
    tests++; if (count8 !== 3'd7 || ev8 !== 1'b1) begin errors++; $display("FAIL down_wrap8: got count=%0d ev=%b want 7/1", count8, ev8); end
    en = 1'b0;
    step();
    tests++; if (count6 !== 3'd5 || ev6 !== 1'b0) begin errors++; $display("FAIL down_wrap_hold: got count=%0d ev=%b want 5/0", count6, ev6); end
  endtask

  task automatic test_up_sat;
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b1; sat_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (count8 !== 3'd7 || ev8 !== 1'b1) begin errors++; $display("FAIL up_sat[%0d]: got count=%0d ev=%b want 7/1", i, count8, ev8); end
    end
    en = 1'b0;
    step();
    tests++; if (ev8 !== 1'b0) begin errors++; $display("FAIL up_sat_release: got %b want 0", ev8); end
  endtask

  task automatic test_random_soak;
    logic [3:0] r8, r6;
    logic [2:0] m8, m6;
    logic       e8, e6;
    int         hold;
    apply_reset();
    m8 = 3'd0; m6 = 3'd0;
    for (int n = 0; n < 50; n++) begin
      en       = 1'($urandom_range(0, 1));
      up_down  = 1'($urandom_range(0, 1));
      sat_mode = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 3) == 0);
      load_val = 3'($urandom_range(0, 7));
      hold     = $urandom_range(5, 20);
      for (int c = 0; c < hold; c++) begin
        r8 = ref_next(8, m8, en, up_down, sat_mode, load, load_val);
        r6 = ref_next(6, m6, en, up_down, sat_mode, load, load_val);
        {e8, m8} = r8;
        {e6, m6} = r6;
        step();
        tests++; if (count8 !== m8 || ev8 !== e8) begin errors++; $display("FAIL soak8[%0d.%0d]: got count=%0d ev=%b want %0d/%b", n, c, count8, ev8, m8, e8); end
        tests++; if (count6 !== m6 || ev6 !== e6) begin errors++; $display("FAIL soak6[%0d.%0d]: got count=%0d ev=%b want %0d/%b", n, c, count6, ev6, m6, e6); end
        tests++; if (count6 > 3'd5) begin errors++; $display("FAIL soak6_range[%0d.%0d]: got %0d want <=5", n, c, count6); end
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_up_wrap();
    test_down_sat();
    test_load_priority();
    test_down_wrap();
    test_up_sat();
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter; next generation of the fixed 3-bit up/down counter. Adds configurable width and modulus, count enable, parallel load, and selectable wrap or saturate behaviour at the range limits. Terminal-count flags and a registered wrap/saturate event pulse let downstream blocks chain or cascade counters without decoding the count value.

## Interface
- WIDTH, 3: counter width in bits; legal range 1..32.
- MODULUS, 8: number of count states; count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; one clock, no other reset.
- en  in  1  count enable; 0 holds count.
- up_down  in  1  direction; 1 = up, 0 = down.
- sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  current count, registered.
- at_max  out  1  combinational; count == MODULUS-1.
- at_min  out  1  combinational; count == 0.
- event_pulse  out  1  registered; one-cycle pulse on the cycle after a wrap or saturation-block event.

## Operation
- Reset (rst=0): count=0, event_pulse=0, asynchronously, regardless of clk. Hence at_min=1 and at_max=0 during reset.
- Priority per rising edge: load > en > hold.
- load=1: count <= load_val if load_val <= MODULUS-1, else count <= MODULUS-1 (clamp). No event_pulse from a load. en and up_down are ignored.
- en=1, load=0, up_down=1:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1, sat_mode=0: count <= 0 and event_pulse <= 1.
  - count == MODULUS-1, sat_mode=1: count holds and event_pulse <= 1.
- en=1, load=0, up_down=0:
  - count > 0: count-1.
  - count == 0, sat_mode=0: count <= MODULUS-1 and event_pulse <= 1.
  - count == 0, sat_mode=1: count holds and event_pulse <= 1.
- en=0, load=0: count holds; event_pulse <= 0.
- event_pulse is 0 on every cycle not listed above. Consecutive blocked attempts in saturate mode keep it high each cycle.
- Arithmetic: next-count logic is computed at WIDTH+1 bits internally. Comparisons are against MODULUS-1, never against 2^WIDTH-1, so non-power-of-two moduli never reach the illegal states MODULUS..2^WIDTH-1.
- Changing up_down or sat_mode mid-count takes effect at the next edge. There is no pipeline and no state beyond count and event_pulse.

## Timing
- Latency is one clock from input sample to count update. at_max and at_min follow count combinationally in the same cycle.
- event_pulse is asserted for exactly the one cycle following the edge that caused the limit event, aligned with the new count value.
- Reset assertion is asynchronous.
- Reset deassertion: the first counting edge is the first rising clk edge with rst=1. The integrator supplies rst deassertion synchronised to clk.
- Reset asserted mid-count: count=0 immediately. Any pending event_pulse is cleared.

## Structure
- Shared package/header `updown_pkg`:
  - direction constants DIR_UP=1, DIR_DOWN=0.
  - mode constants MODE_WRAP=0, MODE_SAT=1.
  - a parameter-legality check macro, used by an elaboration-time assertion on WIDTH and MODULUS.
- Single module. No sub-module: the next-state logic is one combinational block plus two registers.
- A cascade wrapper may instantiate multiple copies, gating each en with the lower stage's at_max/at_min. That wrapper is out of scope here.

## Test plan
- Reset mid-count: WIDTH=3, MODULUS=8, count at 5, drive rst=0 between edges -> count=0 immediately, event_pulse=0, at_min=1.
- Up wrap: MODULUS=8, up_down=1, sat_mode=0, en=1 from 0 for 9 edges -> 1..7,0,1. event_pulse high only in the cycle count shows 0.
- Down saturate: MODULUS=6 (WIDTH=3), load_val=2, then up_down=0, sat_mode=1 for 4 edges -> 1,0,0,0. event_pulse high on the last two cycles. Count never shows 6 or 7.
- Load priority and clamp: MODULUS=6, load=1, en=1, load_val=7 -> count=5, at_max=1, event_pulse=0. Next, load_val=3 -> count=3.
- Non-power-of-two down wrap: MODULUS=6, count=0, up_down=0, sat_mode=0 -> count=5, event_pulse=1. en=0 on the next edge -> count holds at 5, event_pulse=0.
- Random soak: 50 random up_down/en/load toggles at 50-200 time-unit intervals, compared against a reference model -> zero mismatches, and count <= MODULUS-1 throughout.
